// File: rtl/alu_gcd_scheduler.sv
// Round-robin two-port scheduler running subtractive GCD jobs
// on the shared two-register subtract ALU.
module ALU (
  input  logic        clk,
  input  logic [31:0] inpA,
  input  logic [31:0] inpB,
  input  logic        selA,
  input  logic        selB,
  input  logic        wrA,
  input  logic        wrB,
  input  logic [1:0]  ALUop,
  output logic [31:0] ALUout,
  output logic [1:0]  sign
);
  logic [31:0] ra;
  logic [31:0] rb;

  always_comb begin
    unique case (ALUop)
      2'd0:    ALUout = ra;
      2'd1:    ALUout = rb;
      2'd2:    ALUout = ra - rb;
      default: ALUout = rb - ra;
    endcase
  end

  // Signed compare: only meaningful while bit 31 of both is clear.
  always_comb begin
    if (ra == rb)
      sign = 2'b00;
    else if ($signed(ra) > $signed(rb))
      sign = 2'b01;
    else
      sign = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (wrA) ra <= selA ? inpA : ALUout;
    if (wrB) rb <= selB ? inpB : ALUout;
  end
endmodule

module alu_gcd_scheduler #(
  parameter int unsigned MAX_ITER = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);
  typedef enum logic [2:0] {
    IDLE, CMP, SUB_A, SUB_B, DONE
  } state_t;

  localparam logic [1:0] OP_A   = 2'd0;
  localparam logic [1:0] OP_B   = 2'd1;
  localparam logic [1:0] OP_AMB = 2'd2;
  localparam logic [1:0] OP_BMA = 2'd3;
  localparam logic [31:0] CAP = MAX_ITER;

  state_t      st, st_d;
  logic        g_q, g_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        rsel_q, rsel_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;
  logic        cap_hit;
  logic        pick;
  logic [31:0] ga, gb;
  logic        sel_a, sel_b, wr_a, wr_b;
  logic [1:0]  op;
  logic [31:0] alu_out;
  logic [1:0]  sign;

  assign pick = (req_valid == 2'b11) ? ~last_q
                                     : req_valid[1];
  assign ga = pick ? req_a1 : req_a0;
  assign gb = pick ? req_b1 : req_b0;

  assign cnt_inc = cnt_q + 32'd1;
  assign cap_hit = (CAP != '0) && (cnt_inc >= CAP);

  ALU u_alu (
    .clk    (clk),
    .inpA   (ga),
    .inpB   (gb),
    .selA   (sel_a),
    .selB   (sel_b),
    .wrA    (wr_a),
    .wrB    (wr_b),
    .ALUop  (op),
    .ALUout (alu_out),
    .sign   (sign)
  );

  always_comb begin
    st_d      = st;
    g_d       = g_q;
    last_d    = last_q;
    err_d     = err_q;
    rsel_d    = rsel_q;
    cnt_d     = cnt_q;
    sel_a     = 1'b0;
    sel_b     = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    op        = OP_A;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (st)
      IDLE: begin
        if (|req_valid) begin
          req_ready = !reset ? 2'b00
                    : (pick ? 2'b10 : 2'b01);
          sel_a  = 1'b1;
          sel_b  = 1'b1;
          wr_a   = 1'b1;
          wr_b   = 1'b1;
          g_d    = pick;
          last_d = pick;
          cnt_d  = '0;
          err_d  = 1'b0;
          rsel_d = 1'b0;
          st_d   = DONE;
          // Zero operands short-circuit; rsel picks reg B.
          priority case (1'b1)
            ga[31] | gb[31]:      err_d  = 1'b1;
            (ga == '0) && (gb == '0): rsel_d = 1'b0;
            ga == '0:             rsel_d = 1'b1;
            gb == '0:             rsel_d = 1'b0;
            default:              st_d   = CMP;
          endcase
        end
      end
      CMP: begin
        op = OP_AMB;
        unique case (sign)
          2'b00:   st_d = DONE;
          2'b01:   st_d = SUB_A;
          default: st_d = SUB_B;
        endcase
      end
      SUB_A: begin
        op    = OP_AMB;
        wr_a  = 1'b1;
        cnt_d = cnt_inc;
        if (cap_hit) begin
          st_d  = DONE;
          err_d = 1'b1;
        end else begin
          st_d = CMP;
        end
      end
      SUB_B: begin
        op    = OP_BMA;
        wr_b  = 1'b1;
        cnt_d = cnt_inc;
        if (cap_hit) begin
          st_d  = DONE;
          err_d = 1'b1;
        end else begin
          st_d = CMP;
        end
      end
      DONE: begin
        op        = rsel_q ? OP_B : OP_A;
        rsp_valid = g_q ? 2'b10 : 2'b01;
        if (rsp_ready[g_q]) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign rsp_data = (st == DONE && !err_q) ? alu_out : '0;
  assign rsp_err  = (st == DONE) && err_q;
  assign busy     = (st != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      g_q    <= 1'b0;
      last_q <= 1'b1;
      err_q  <= 1'b0;
      rsel_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st     <= st_d;
      g_q    <= g_d;
      last_q <= last_d;
      err_q  <= err_d;
      rsel_q <= rsel_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: doc/alu_gcd_scheduler.md
# alu_gcd_scheduler

Sequencer and two-port arbiter for the shared two-register subtract ALU (registers A/B, ops A, B, A−B, B−A, 2-bit sign). Two requesters submit operand pairs through valid/ready handshakes. The block grants the ALU round-robin, runs subtractive GCD on it, and returns the result through a per-requester response handshake. It instantiates the existing `ALU` module internally and is the only driver of its selA/selB/wrA/wrB/ALUop.

## Interface
- `MAX_ITER`, default 0: cap on subtract steps per job; 0 disables the cap.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  2: bit i = requester i has an operand pair.
- `req_ready`  out  2: one-cycle grant/accept pulse to requester i.
- `req_a0`, `req_b0`  in  32 each: requester 0 operands, unsigned.
- `req_a1`, `req_b1`  in  32 each: requester 1 operands, unsigned.
- `rsp_valid`  out  2: bit i = result for requester i is on `rsp_data`.
- `rsp_ready`  in  2: requester i takes the result.
- `rsp_data`  out  32: GCD result; 0 when `rsp_err`.
- `rsp_err`  out  1: job rejected or aborted; qualified by `rsp_valid`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, CMP, SUB_A, SUB_B, DONE.
- **IDLE**
  - With no `req_valid`: no ALU writes, ALUop=A.
  - With any `req_valid`: grant one requester g. If both request, g is the one not granted last. The last-grant register resets to 1, so requester 0 wins first.
  - Grant cycle: `req_ready[g]`=1; selA=selB=1; wrA=wrB=1; ALU inpA/inpB muxed from g's operands. Latch g and clear the iteration counter.
- **Grant-cycle checks**, evaluated on g's raw operands in this priority order:
  - bit 31 of either operand set → DONE with err=1. The signed sign compare is invalid for these values.
  - both operands 0 → DONE, result 0.
  - A operand 0 → DONE, result = B.
  - B operand 0 → DONE, result = A.
  - otherwise → CMP.
- **CMP**: ALUop=A−B, no writes.
  - sign=00 → DONE.
  - sign=01 → SUB_A.
  - sign=10 → SUB_B.
- **SUB_A**: ALUop=A−B, selA=0, wrA=1 (A←A−B). Then CMP.
- **SUB_B**: ALUop=B−A, selB=0, wrB=1 (B←B−A). Then CMP.
- **Iteration cap**: each SUB_x increments the counter. If MAX_ITER≠0 and the counter reaches MAX_ITER on entering CMP, go to DONE with err=1.
- **DONE**
  - ALUop=B if the result-select flag marks B, else A.
  - `rsp_data`=ALUout, or 0 if err.
  - `rsp_valid[g]`=1, held with `rsp_data`/`rsp_err` stable until `rsp_ready[g]`.
  - On the handshake cycle → IDLE.
  - `rsp_ready` of the non-granted port is ignored.
- The non-granted requester keeps `req_valid` asserted and waits; its operands are not sampled.
- A requester must not deassert `req_valid` before `req_ready`. If it does, nothing is granted.

## Timing
- **Reset (`reset`=0)**, asynchronous:
  - state=IDLE; `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0; last-grant=1; counter=0.
  - ALU A/B registers are not reset and are don't-care.
  - Reset mid-job drops the job with no response. Deassertion is synchronous to `clk`; the first grant can occur on the first edge after deassertion.
- **Outputs**: `req_ready` and `rsp_valid` are combinational from state plus arbitration inputs. `rsp_data` is ALUout in DONE, else 0.
- **Latency**, grant edge = cycle 0:
  - Result is valid 1+2k+1 cycles after grant, where k = number of subtract steps.
  - Zero/err rejects are valid at cycle 1.
- **Equal operands**: CMP→DONE in one step, valid at cycle 2.
- **Response handshake**: a response accepted in cycle t allows the next grant no earlier than t+1. Minimum IDLE dwell is one cycle.
- **Simultaneous events**:
  - `req_valid` during DONE is held off until IDLE.
  - Both requesters arriving in the same cycle are resolved by round-robin only.

## Test plan
- **Single job**: req0 (12,8).
  - `req_ready[0]` pulses at cycle 0.
  - State sequence CMP, SUB_A, CMP, SUB_B, CMP, DONE.
  - `rsp_valid[0]` at cycle 6, `rsp_data`=4, `rsp_err`=0.
- **Round-robin**: after reset, req0 (9,9) and req1 (21,14) are both held valid.
  - req0 is granted first and gets 9.
  - req1 is granted next and gets 7.
  - Re-issuing both again grants req0 (alternation).
- **Zero and illegal operands**:
  - (0,5) → 5 at cycle 1.
  - (6,0) → 6.
  - (0,0) → 0.
  - (0x8000_0001,3) → `rsp_err`=1, `rsp_data`=0.
  - None of these enter CMP.
- **Backpressure**: (100,75) → 25.
  - Hold `rsp_ready[0]`=0 for 5 cycles: `rsp_valid`/`rsp_data` stay stable and `busy`=1.
  - req1 pending throughout is not granted until the cycle after acceptance.
- **Iteration cap**: MAX_ITER=4, (1000,1).
  - `rsp_err`=1 after 4 SUB_A steps (valid at cycle 9).
  - MAX_ITER=0 with (7,1) → 1 after 6 steps.
- **Reset mid-job**: assert `reset`=0 asynchronously during SUB_B of (48,18).
  - All outputs go to 0 immediately.
  - After release, a new req1 (48,18) returns 6 with no stale response.
